// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM state
// codes and the datapath mux/ALU select encodings.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsource_e;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control FSM and the datapath/memory: opcode and memory
// handshake in, all datapath control and status out.
interface multicycle_control_if #(
  parameter int OPW  = 6,
  parameter int CNTW = 16
) ();
  logic [OPW-1:0]  opcode;
  logic            mem_ready;
  logic            pcwrite;
  logic            pcwritecond;
  logic            iord;
  logic            memread;
  logic            memwrite;
  logic            irwrite;
  logic            memtoreg;
  logic            regdst;
  logic            regwrite;
  logic            alusrca;
  logic [1:0]      alusrcb;
  logic [1:0]      aluop;
  logic [1:0]      pcsource;
  logic            illegal;
  logic            instr_done;
  logic [CNTW-1:0] retired;
  logic [3:0]      state;

  modport master (
    output opcode, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, aluop, pcsource, illegal,
           instr_done, retired, state
  );

  modport slave (
    input  opcode, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
           regdst, regwrite, alusrca, alusrcb, aluop, pcsource, illegal,
           instr_done, retired, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory wait states, illegal-opcode
// detection and a wrapping retired-instruction counter.
//
// state      | meaning
// FETCH  (0) | read instruction at PC, PC+4; waits on memory
// DECODE (1) | register read, branch target; dispatch on opcode
// MEMADR (2) | effective address for LW/SW
// MEMRD  (3) | data read; waits on memory
// MEMWB  (4) | load result to rt
// MEMWR  (5) | data write; waits on memory
// EXEC   (6) | R-type ALU operation
// RWB    (7) | R-type result to rd
// BRANCH (8) | BEQ compare and conditional PC load
// ADDIEX (9) | ADDI ALU operation
// ADDIWB(10) | ADDI result to rt
// JUMP  (11) | PC load with jump target
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPW         = 6,
  parameter int MEM_WAIT_EN = 1,
  parameter int CNTW        = 16
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_control_if.slave bus
);

  logic [3:0]      state_q, state_d;
  logic [CNTW-1:0] retired_q;
  logic [5:0]      op;
  logic            ready;

  assign op          = bus.opcode[5:0];
  assign ready       = (MEM_WAIT_EN == 0) ? 1'b1 : bus.mem_ready;
  assign bus.state   = state_q;
  assign bus.retired = retired_q;

  // State register; reset restarts at FETCH.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (ready) state_d = S_MEMWB;
      S_MEMWR:  if (ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Per-state datapath control; commit strobes are gated off during reset.
  always_comb begin
    bus.pcwrite     = 1'b0;
    bus.pcwritecond = 1'b0;
    bus.iord        = 1'b0;
    bus.memread     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.irwrite     = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.regdst      = 1'b0;
    bus.regwrite    = 1'b0;
    bus.alusrca     = 1'b0;
    bus.alusrcb     = SRCB_B;
    bus.aluop       = ALU_ADD;
    bus.pcsource    = PCSRC_ALU;
    bus.illegal     = 1'b0;
    bus.instr_done  = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.memread = 1'b1;
        bus.alusrcb = SRCB_FOUR;
        bus.pcwrite = ready;
        bus.irwrite = ready;
      end
      S_DECODE: begin
        bus.alusrcb = SRCB_IMM_SH;
        bus.illegal = !op_is_legal(op);
      end
      S_MEMADR, S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
      end
      S_MEMWR: begin
        bus.memwrite   = 1'b1;
        bus.iord       = 1'b1;
        bus.instr_done = ready;
      end
      S_MEMWB: begin
        bus.memtoreg   = 1'b1;
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_EXEC: begin
        bus.alusrca = 1'b1;
        bus.aluop   = ALU_FUNCT;
      end
      S_RWB: begin
        bus.regdst     = 1'b1;
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca     = 1'b1;
        bus.aluop       = ALU_SUB;
        bus.pcwritecond = 1'b1;
        bus.pcsource    = PCSRC_ALUOUT;
        bus.instr_done  = 1'b1;
      end
      S_ADDIWB: begin
        bus.regwrite   = 1'b1;
        bus.instr_done = 1'b1;
      end
      S_JUMP: begin
        bus.pcwrite    = 1'b1;
        bus.pcsource   = PCSRC_JUMP;
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      bus.pcwrite     = 1'b0;
      bus.irwrite     = 1'b0;
      bus.regwrite    = 1'b0;
      bus.memwrite    = 1'b0;
      bus.pcwritecond = 1'b0;
      bus.illegal     = 1'b0;
      bus.instr_done  = 1'b0;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNTW.
  always_ff @(posedge clk) begin
    if (reset)               retired_q <= '0;
    else if (bus.instr_done) retired_q <= retired_q + 1'b1;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control. A second instance with
// a 2-bit counter shares the inputs to exercise counter wrap.
module tb_multicycle_control;

  typedef struct {
    logic [3:0]  st;
    logic [17:0] ctl;
    int unsigned ret;
  } cyc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_if #(.OPW(6), .CNTW(16)) bus ();
  multicycle_control_if #(.OPW(6), .CNTW(2))  bus2 ();

  assign bus2.opcode    = bus.opcode;
  assign bus2.mem_ready = bus.mem_ready;

  multicycle_control #(.OPW(6), .MEM_WAIT_EN(1), .CNTW(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  multicycle_control #(.OPW(6), .MEM_WAIT_EN(1), .CNTW(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave));

  cyc_t        cyc_q[$];
  int          lat_q[$];
  int unsigned count = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          ncyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  // Expected control vector from the per-state output list:
  // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,
  //  regwrite,alusrca,alusrcb[2],aluop[2],pcsource[2],illegal,instr_done}
  function automatic logic [17:0] exp_ctl(input logic [3:0] st, input logic rdy,
                                          input logic rst, input logic bad);
    logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, ill, done;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, ill, done} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0:       begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
      4'd1:       begin asb = 2'b11; ill = bad; end
      4'd2, 4'd9: begin asa = 1; asb = 2'b10; end
      4'd3:       begin mr = 1; io = 1; end
      4'd4:       begin m2r = 1; rw = 1; done = 1; end
      4'd5:       begin mw = 1; io = 1; done = rdy; end
      4'd6:       begin asa = 1; aop = 2'b10; end
      4'd7:       begin rd = 1; rw = 1; done = 1; end
      4'd8:       begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1; end
      4'd10:      begin rw = 1; done = 1; end
      4'd11:      begin pw = 1; psrc = 2'b10; done = 1; end
      default: ;
    endcase
    if (rst) begin
      pw = 0; irw = 0; rw = 0; mw = 0; pwc = 0; ill = 0; done = 0;
    end
    return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill, done};
  endfunction

  // One clock of stimulus plus the expected observation for that cycle.
  task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input logic bad);
    cyc_t c;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    c.st  = st;
    c.ctl = exp_ctl(st, rdy, rst, bad);
    c.ret = count;
    cyc_q.push_back(c);
    if (rst) count = 0;
    else if (c.ctl[0]) count++;
  endtask

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drives one instruction; memory states stall for wf (fetch) / wm (data).
  // With abort set, reset is raised in the first MEMWR cycle of an SW.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input bit abort);
    bit bad;
    bad = !legal(op);
    if (!abort) begin
      if (bad)                                      lat_q.push_back(wf + 2);
      else if (op == 6'b100011)                     lat_q.push_back(wf + wm + 5);
      else if (op == 6'b101011)                     lat_q.push_back(wf + wm + 4);
      else if (op == 6'b000100 || op == 6'b000010)  lat_q.push_back(wf + 3);
      else                                          lat_q.push_back(wf + 4);
    end
    for (int i = 0; i < wf; i++) step(0, rnd_op(), 0, 4'd0, 0);
    step(0, rnd_op(), 1, 4'd0, 0);
    step(0, op, rnd_bit(), 4'd1, bad);
    if (bad) return;
    case (op)
      6'b100011: begin
        step(0, op, rnd_bit(), 4'd2, 0);
        for (int i = 0; i < wm; i++) step(0, rnd_op(), 0, 4'd3, 0);
        step(0, rnd_op(), 1, 4'd3, 0);
        step(0, rnd_op(), rnd_bit(), 4'd4, 0);
      end
      6'b101011: begin
        step(0, op, rnd_bit(), 4'd2, 0);
        if (abort) begin
          step(1, rnd_op(), 1, 4'd5, 0);
        end else begin
          for (int i = 0; i < wm; i++) step(0, rnd_op(), 0, 4'd5, 0);
          step(0, rnd_op(), 1, 4'd5, 0);
        end
      end
      6'b000000: begin
        step(0, rnd_op(), rnd_bit(), 4'd6, 0);
        step(0, rnd_op(), rnd_bit(), 4'd7, 0);
      end
      6'b000100: step(0, rnd_op(), rnd_bit(), 4'd8, 0);
      6'b001000: begin
        step(0, rnd_op(), rnd_bit(), 4'd9, 0);
        step(0, rnd_op(), rnd_bit(), 4'd10, 0);
      end
      default:   step(0, rnd_op(), rnd_bit(), 4'd11, 0);
    endcase
  endtask

  // Monitor: per-cycle scoreboard plus completion-latency scoreboard.
  initial begin
    cyc_t c;
    logic [17:0] act;
    forever begin
      @(negedge clk);
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        act = {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
               bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca,
               bus.alusrcb, bus.aluop, bus.pcsource, bus.illegal, bus.instr_done};
        chk("state", 32'(bus.state), 32'(c.st));
        chk("ctl", 32'(act), 32'(c.ctl));
        chk("retired", 32'(bus.retired), c.ret & 32'hFFFF);
        chk("state_w2", 32'(bus2.state), 32'(c.st));
        chk("retired_w2", 32'(bus2.retired), c.ret & 32'h3);
      end
      if (reset) begin
        ncyc = 0;
      end else begin
        ncyc++;
        if (bus.instr_done || bus.illegal) begin
          if (lat_q.size() == 0) chk("unexpected_completion", 32'(ncyc), 32'd0);
          else                   chk("latency", 32'(ncyc), 32'(lat_q.pop_front()));
          ncyc = 0;
        end
      end
    end
  end

  initial begin
    int wf, wm, sel;
    logic [5:0] op;
    logic [5:0] ops[6];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    bus.opcode    = '0;
    bus.mem_ready = 1'b0;

    step(1, 6'd0, 0, 4'd0, 0);
    step(1, 6'd0, 1, 4'd0, 0);

    run_instr(6'b000000, 0, 0, 0);
    run_instr(6'b100011, 0, 2, 0);
    run_instr(6'b101011, 0, 0, 0);
    run_instr(6'b000100, 0, 0, 0);
    run_instr(6'b001000, 0, 0, 0);
    run_instr(6'b000010, 0, 0, 0);
    run_instr(6'b111111, 0, 0, 0);
    run_instr(6'b101011, 1, 0, 1);

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 7);
      op  = (sel < 6) ? ops[sel] : rnd_op();
      wf  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      wm  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      run_instr(op, wf, wm, 0);
    end

    step(0, 6'd0, 0, 4'd0, 0);
    step(0, 6'd0, 0, 4'd0, 0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("cyc_queue_drained", 32'(cyc_q.size()), 32'd0);
    chk("lat_queue_drained", 32'(lat_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
